bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq_pkg.sv | 24 ++
 rtl/bin2bcd_seq_digit_adj.sv | 18 +
 rtl/bin2bcd_seq.sv | 207 ++++++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - BCD digit width
//   - double-dabble adjust threshold and increment
// No ports (package).
// -----------------------------------------------------------------------------
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;

  // A digit of 5 or more would reach 10 or more after the next left shift,
  // so it is pre-corrected by +3 so that the shift carries into the next digit.
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble correction for one BCD digit:
//   o_digit = (i_digit >= 5) ? i_digit + 3 : i_digit
// Ports:
//   i_digit  in   4  scratch digit before the shift
//   o_digit  out  4  corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit + ADJ_ADD) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential (shift-and-add-3) binary to packed-BCD converter with a
// leading-zero mask for seven-segment blanking.
//
// Parameters:
//   BIN_W   binary input width (default 21)
//   DIGITS  BCD digits produced (default 8); the pairing must satisfy
//           10**DIGITS > 2**BIN_W, otherwise the top of the result is lost
//           silently (no overflow flag exists).
//
// Ports:
//   clk      in   1          clock, rising edge
//   rst      in   1          asynchronous reset, active low
//   start    in   1          conversion request, sampled only in IDLE
//   bin      in   BIN_W      value captured on the accepted start edge
//   busy     out  1          high in SHIFT and DONE
//   done     out  1          one-cycle completion pulse (DONE state)
//   bcd      out  4*DIGITS   result, digit 0 in [3:0], held between completions
//   lz_mask  out  DIGITS     bit i set when digit i is significant; bit 0 always set
//
// Optional feature, macro BIN2BCD_AUTO_EN:
//   when defined, in IDLE a bin value that differs from the last captured one
//   starts a conversion as if start were pulsed.
//
// Timing: start accepted at edge k, shifts on edges k+1..k+BIN_W, result
// loaded and DONE entered at edge k+BIN_W+1, back to IDLE one edge later.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start (or auto trigger); outputs hold last result
// SHIFT  | BIN_W adjust+shift steps, then one step to publish the result
// DONE   | result visible on bcd/lz_mask, done pulse high for one cycle
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 21,
  parameter int DIGITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]         lz_mask
);

  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int SCR_W  = DIGIT_W * DIGITS;
  localparam int PAIR_W = SCR_W + BIN_W;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BIN_W-1:0]   r_bin_sr;
  logic [SCR_W-1:0]   r_scratch;
  logic [SCR_W-1:0]   w_scratch_adj;
  logic [PAIR_W-1:0]  w_pair_shl;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCR_W-1:0]   r_bcd;
  logic [DIGITS-1:0]  r_lz;
  logic [DIGITS-1:0]  w_lz;
  logic               w_any_above;
  logic               w_trigger;
  logic               w_capture;
  logic               w_shift;
  logic               w_finish;

  // ---------------------------------------------------------------------------
  // Per-digit add-3 correction on the current scratch value
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_scratch[g*DIGIT_W +: DIGIT_W]),
      .o_digit (w_scratch_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Corrected scratch and binary shifted left as one register pair; the
  // binary MSB lands in the LSB of digit 0.
  assign w_pair_shl = {w_scratch_adj, r_bin_sr} << 1;

  // ---------------------------------------------------------------------------
  // Conversion trigger
  // ---------------------------------------------------------------------------
`ifdef BIN2BCD_AUTO_EN
  logic [BIN_W-1:0] r_last;

  assign w_trigger = start | (bin != r_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= '0;
    end else if (w_capture) begin
      r_last <= bin;
    end
  end
`else
  assign w_trigger = start;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_shift     = 1'b0;
    w_finish    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (r_cnt != '0) begin
          w_shift = 1'b1;
        end else begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift-step down-counter: loaded with BIN_W on capture, the conversion
  // publishes once it reaches terminal count zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_capture) begin
      r_cnt <= CNT_W'(BIN_W);
    end else if (w_shift) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scratch / binary shift pair
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bin_sr  <= '0;
      r_scratch <= '0;
    end else if (w_capture) begin
      r_bin_sr  <= bin;
      r_scratch <= '0;
    end else if (w_shift) begin
      r_scratch <= w_pair_shl[PAIR_W-1:BIN_W];
      r_bin_sr  <= w_pair_shl[BIN_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero mask of the finished scratch: a digit is significant when it
  // or any digit above it is non-zero.  Digit 0 always shows.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_lz        = '0;
    w_any_above = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_any_above = w_any_above | (|r_scratch[i*DIGIT_W +: DIGIT_W]);
      w_lz[i]     = w_any_above;
    end
    w_lz[0] = 1'b1;
  end

  // Outputs only move on the publish edge, so scratch values never leak out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcd <= '0;
      r_lz  <= DIGITS'(1);
    end else if (w_finish) begin
      r_bcd <= r_scratch;
      r_lz  <= w_lz;
    end
  end

  assign bcd     = r_bcd;
  assign lz_mask = r_lz;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  localparam int BIN_W  = 21;
  localparam int DIGITS = 8;

  logic                  clk   = 1'b0;
  logic                  rst   = 1'b0;
  logic                  start = 1'b0;
  logic [BIN_W-1:0]      bin   = '0;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     lz_mask;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .lz_mask (lz_mask)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   lz;
    int unsigned         cyc;
  } exp_t;

  exp_t                q[$];
  exp_t                m_e;
  int                  n_chk = 0;
  int                  n_pass = 0;
  logic [4*DIGITS-1:0] hold_bcd = '0;
  logic [DIGITS-1:0]   hold_lz  = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: decimal digits by repeated division; a digit is significant
  // when the value reaches that power of ten.  Done expected BIN_W+1 edges
  // after the accept edge, which is the edge following the drive cycle c.
  function automatic exp_t model(input int unsigned v, input int unsigned c);
    exp_t            e;
    int unsigned     t;
    longint unsigned p;
    t = v;
    p = 1;
    e.bcd = '0;
    e.lz  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      e.bcd[4*i +: 4] = 4'(t % 10);
      t = t / 10;
      e.lz[i] = (i == 0) || (longint'(v) >= p);
      p = p * 10;
    end
    e.cyc = c + BIN_W + 2;
    return e;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      hold_bcd = '0;
      hold_lz  = 1;
      chk("rst_bcd", 64'(bcd), 64'h0);
      chk("rst_lz", 64'(lz_mask), 64'h1);
      chk("rst_done", 64'(done), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
    end else if (done) begin
      chk("done_with_busy", 64'(busy), 64'h1);
      if (q.size() == 0) begin
        chk("unexpected_done", 64'h1, 64'h0);
      end else begin
        m_e = q.pop_front();
        chk("bcd", 64'(bcd), 64'(m_e.bcd));
        chk("lz_mask", 64'(lz_mask), 64'(m_e.lz));
        chk("latency_cycle", 64'(cyc), 64'(m_e.cyc));
        hold_bcd = m_e.bcd;
        hold_lz  = m_e.lz;
      end
    end else begin
      chk("hold_bcd", 64'(bcd), 64'(hold_bcd));
      chk("hold_lz", 64'(lz_mask), 64'(hold_lz));
    end
  end

  task automatic issue(input int unsigned v);
    @(negedge clk);
    bin   = BIN_W'(v);
    start = 1'b1;
    q.push_back(model(v, cyc));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'h1);
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else chk("busy_during_conv", 64'(busy), 64'h1);
    end
    if (!seen) chk("done_timeout", 64'h0, 64'h1);
  endtask

  task automatic after_done();
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'h0);
    chk("idle_done", 64'(done), 64'h0);
  endtask

  task automatic convert(input int unsigned v);
    bit seen;
    issue(v);
    wait_done(seen);
    after_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    int unsigned v;
    int unsigned gap;

    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 64'(busy), 64'h0);

    // Basic values and digit boundaries
    convert(0);
    convert(1234);
    convert(9);
    convert(10);
    convert(999999);
    convert(1000000);

    // Max value, with an ignored start mid-conversion
    issue(2097151);
    repeat (4) @(negedge clk);
    bin   = BIN_W'(7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin   = BIN_W'(2097151);
    chk("busy_ignore_start", 64'(busy), 64'h1);
    wait_done(seen);
    after_done();

    // Start presented during the DONE cycle is ignored
    issue(4321);
    wait_done(seen);
    start = 1'b1;
    bin   = BIN_W'(55);
    @(negedge clk);
    start = 1'b0;
    bin   = BIN_W'(4321);
    chk("done_start_ignored_busy", 64'(busy), 64'h0);
    repeat (3) @(negedge clk);
    chk("done_start_still_idle", 64'(busy), 64'h0);

    // Reset mid-conversion aborts without a done pulse
    issue(999999);
    repeat (9) @(negedge clk);
    #1 rst = 1'b0;
    bin = '0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_done", 64'(done), 64'h0);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle_busy", 64'(busy), 64'h0);
    convert(999999);

`ifdef BIN2BCD_AUTO_EN
    // Value change alone triggers exactly one conversion
    @(negedge clk);
    bin = BIN_W'(5);
    q.push_back(model(5, cyc));
    wait_done(seen);
    after_done();
    repeat (30) @(negedge clk);
    chk("auto_single_conv", 64'(busy), 64'h0);
`endif

    // Randomized conversions with random idle gaps
    for (int n = 0; n < 12; n++) begin
      v   = $urandom_range(0, (1 << BIN_W) - 1);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      convert(v);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
